// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit.
// FSM state encodings and the default register-index width.
package hazard_pkg;

  localparam int RNBITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_MEM_WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use comparator between the load in ID/EX
// and the source registers of the instruction in ID.
module hazard_loaduse_detect
  import hazard_pkg::*;
#(
  parameter int RNBITS = RNBITS_DEF
) (
  input  logic              i_EX_MemRead,
  input  logic [RNBITS-1:0] i_EX_Rt,
  input  logic [RNBITS-1:0] i_ID_Rs,
  input  logic [RNBITS-1:0] i_ID_Rt,
  input  logic              i_ID_UsesRt,
  output logic              o_LoadUse
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = (i_EX_Rt == i_ID_Rs);
  assign w_rt_hit = i_ID_UsesRt && (i_EX_Rt == i_ID_Rt);

  // register zero never carries a real dependency
  assign o_LoadUse = i_EX_MemRead
                  && (i_EX_Rt != '0)
                  && (w_rs_hit || w_rt_hit);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard FSM: taken-branch flush, memory wait, load-use stall.
// Define HAZARD_STATS_EN to add saturating event counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int RNBITS  = RNBITS_DEF,
  parameter int CNTBITS = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [RNBITS-1:0] i_ID_Rs,
  input  logic [RNBITS-1:0] i_ID_Rt,
  input  logic              i_ID_UsesRt,
  input  logic              i_EX_MemRead,
  input  logic [RNBITS-1:0] i_EX_Rt,
  input  logic              i_MEM_Taken,
  input  logic              i_MemBusy,
  output logic              o_PC_Write,
  output logic              o_IFID_Write,
  output logic              o_IFID_Flush,
  output logic              o_IDEX_Bubble,
  output logic              o_EXMEM_Flush,
  output logic              o_Freeze,
  output logic [1:0]        o_State
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNTBITS-1:0] o_StallCount,
  output logic [CNTBITS-1:0] o_FlushCount,
  output logic [CNTBITS-1:0] o_WaitCount
`endif
);

  if (CNTBITS < 1) begin : g_bad_cnt
    $error("CNTBITS must be at least 1");
  end

  state_t r_state;
  state_t w_next;
  logic   w_loaduse;
  logic   w_taken;
  logic   w_busy;
  logic   w_stall;
  logic   w_flush_hold;

  hazard_loaduse_detect #(
    .RNBITS(RNBITS)
  ) u_detect (
    .i_EX_MemRead(i_EX_MemRead),
    .i_EX_Rt     (i_EX_Rt),
    .i_ID_Rs     (i_ID_Rs),
    .i_ID_Rt     (i_ID_Rt),
    .i_ID_UsesRt (i_ID_UsesRt),
    .o_LoadUse   (w_loaduse)
  );

  // mutually exclusive events, in priority order
  assign w_taken = i_MEM_Taken;
  assign w_busy  = !i_MEM_Taken && i_MemBusy;
  assign w_stall = !i_MEM_Taken && !i_MemBusy
                && w_loaduse
                && (r_state != ST_LOAD_STALL);
  assign w_flush_hold = (r_state == ST_FLUSH)
                     && !w_taken && !w_busy && !w_stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next        = ST_RUN;
    o_PC_Write    = 1'b1;
    o_IFID_Write  = 1'b1;
    o_IFID_Flush  = 1'b0;
    o_IDEX_Bubble = 1'b0;
    o_EXMEM_Flush = 1'b0;
    o_Freeze      = 1'b0;
    unique case (1'b1)
      w_taken: begin
        o_IFID_Flush  = 1'b1;
        o_IDEX_Bubble = 1'b1;
        o_EXMEM_Flush = 1'b1;
        w_next        = ST_FLUSH;
      end
      w_busy: begin
        o_PC_Write   = 1'b0;
        o_IFID_Write = 1'b0;
        o_Freeze     = 1'b1;
        w_next       = ST_MEM_WAIT;
      end
      w_stall: begin
        o_PC_Write    = 1'b0;
        o_IFID_Write  = 1'b0;
        o_IDEX_Bubble = 1'b1;
        w_next        = ST_LOAD_STALL;
      end
      w_flush_hold: begin
        // wrong-path instruction still sits in ID
        o_IDEX_Bubble = 1'b1;
      end
      default: ;
    endcase
    if (i_reset) begin
      w_next        = ST_RUN;
      o_PC_Write    = 1'b0;
      o_IFID_Write  = 1'b0;
      o_IFID_Flush  = 1'b1;
      o_IDEX_Bubble = 1'b1;
      o_EXMEM_Flush = 1'b1;
      o_Freeze      = 1'b0;
    end
  end

  assign o_State = r_state;

`ifdef HAZARD_STATS_EN
  logic [CNTBITS-1:0] r_stall_cnt;
  logic [CNTBITS-1:0] r_flush_cnt;
  logic [CNTBITS-1:0] r_wait_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNTBITS'(1);
      if (w_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNTBITS'(1);
      if (w_busy && (r_wait_cnt != '1))
        r_wait_cnt <= r_wait_cnt + CNTBITS'(1);
    end
  end

  assign o_StallCount = r_stall_cnt;
  assign o_FlushCount = r_flush_cnt;
  assign o_WaitCount  = r_wait_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit.
// Control vector order: PCW IFW IFF BUB EXF FRZ ST[1:0].
module tb_hazard_unit;

  localparam int RN = 5;
  localparam int CN = 16;

  localparam logic [7:0] V_RST   = 8'b00_111_0_00;
  localparam logic [7:0] V_RUN   = 8'b11_000_0_00;
  localparam logic [7:0] V_LS    = 8'b11_000_0_01;
  localparam logic [7:0] V_STALL = 8'b00_010_0_00;
  localparam logic [7:0] V_TAKEN = 8'b11_111_0_00;
  localparam logic [7:0] V_FLUSH = 8'b11_010_0_10;
  localparam logic [7:0] V_FRZ   = 8'b00_000_1_00;
  localparam logic [7:0] V_WAIT  = 8'b00_000_1_11;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [RN-1:0] i_ID_Rs;
  logic [RN-1:0] i_ID_Rt;
  logic          i_ID_UsesRt;
  logic          i_EX_MemRead;
  logic [RN-1:0] i_EX_Rt;
  logic          i_MEM_Taken;
  logic          i_MemBusy;
  logic          o_PC_Write;
  logic          o_IFID_Write;
  logic          o_IFID_Flush;
  logic          o_IDEX_Bubble;
  logic          o_EXMEM_Flush;
  logic          o_Freeze;
  logic [1:0]    o_State;
`ifdef HAZARD_STATS_EN
  logic [CN-1:0] o_StallCount;
  logic [CN-1:0] o_FlushCount;
  logic [CN-1:0] o_WaitCount;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  hazard_unit #(
    .RNBITS (RN),
    .CNTBITS(CN)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_ID_Rs      (i_ID_Rs),
    .i_ID_Rt      (i_ID_Rt),
    .i_ID_UsesRt  (i_ID_UsesRt),
    .i_EX_MemRead (i_EX_MemRead),
    .i_EX_Rt      (i_EX_Rt),
    .i_MEM_Taken  (i_MEM_Taken),
    .i_MemBusy    (i_MemBusy),
    .o_PC_Write   (o_PC_Write),
    .o_IFID_Write (o_IFID_Write),
    .o_IFID_Flush (o_IFID_Flush),
    .o_IDEX_Bubble(o_IDEX_Bubble),
    .o_EXMEM_Flush(o_EXMEM_Flush),
    .o_Freeze     (o_Freeze),
    .o_State      (o_State)
`ifdef HAZARD_STATS_EN
    ,
    .o_StallCount (o_StallCount),
    .o_FlushCount (o_FlushCount),
    .o_WaitCount  (o_WaitCount)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic tk, input logic bz,
                     input logic mr, input logic [RN-1:0] ert,
                     input logic [RN-1:0] rs, input logic [RN-1:0] rt,
                     input logic ur);
    i_MEM_Taken  = tk;
    i_MemBusy    = bz;
    i_EX_MemRead = mr;
    i_EX_Rt      = ert;
    i_ID_Rs      = rs;
    i_ID_Rt      = rt;
    i_ID_UsesRt  = ur;
  endtask

  // check combinational outputs, then commit one clock edge
  task automatic cyc(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    #1;
    got = {o_PC_Write, o_IFID_Write, o_IFID_Flush, o_IDEX_Bubble,
           o_EXMEM_Flush, o_Freeze, o_State};
    check(tag, 32'(got), 32'(exp));
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(posedge i_clk);
    #1;
    cyc("rst0", V_RST);
    cyc("rst1", V_RST);
    i_reset = 1'b0;
    cyc("idle", V_RUN);

    drv(0, 0, 1, 8, 8, 0, 0);
    cyc("lu_stall", V_STALL);
    cyc("lu_suppr", V_LS);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("lu_done", V_RUN);

    drv(0, 0, 1, 0, 0, 0, 0);
    cyc("reg_zero", V_RUN);

    drv(0, 0, 1, 9, 1, 9, 0);
    cyc("rt_masked", V_RUN);
    drv(0, 0, 1, 9, 1, 9, 1);
    cyc("rt_used", V_STALL);
    drv(1, 0, 1, 9, 1, 9, 1);
    cyc("tk_in_ls", 8'b11_111_0_01);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("flush_a", V_FLUSH);
    cyc("flush_a_end", V_RUN);

    drv(1, 0, 1, 8, 8, 0, 0);
    cyc("tk_lu", V_TAKEN);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("flush_b", V_FLUSH);
    cyc("flush_b_end", V_RUN);

    drv(0, 1, 0, 0, 0, 0, 0);
    cyc("wait0", V_FRZ);
    cyc("wait1", V_WAIT);
    cyc("wait2", V_WAIT);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("wait_end", 8'b11_000_0_11);
`ifdef HAZARD_STATS_EN
    check("wait_cnt", 32'(o_WaitCount), 32'd3);
    check("stall_cnt", 32'(o_StallCount), 32'd2);
    check("flush_cnt", 32'(o_FlushCount), 32'd2);
`endif
    cyc("wait_run", V_RUN);

    drv(0, 1, 1, 8, 8, 0, 0);
    cyc("bz_lu", V_FRZ);
    drv(0, 0, 1, 8, 8, 0, 0);
    cyc("bz_lu_re", 8'b00_010_0_11);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("bz_lu_ls", V_LS);

    drv(0, 1, 0, 0, 0, 0, 0);
    cyc("tk_wait0", V_FRZ);
    drv(1, 1, 0, 0, 0, 0, 0);
    cyc("tk_wait1", 8'b11_111_0_11);
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("flush_c", V_FLUSH);

    drv(0, 1, 0, 0, 0, 0, 0);
    cyc("rw_wait0", V_FRZ);
    cyc("rw_wait1", V_WAIT);
    i_reset = 1'b1;
    cyc("rst_wait", V_RST);
    i_reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc("post_rst", V_RUN);
`ifdef HAZARD_STATS_EN
    check("cnt_clr", 32'(o_WaitCount), 32'd0);
`endif
    drv(0, 0, 1, 8, 8, 0, 0);
    cyc("post_rst_lu", V_STALL);
    cyc("post_rst_ls", V_LS);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter RNBITS, default 5, meaning register-index width.
REQ-002 SHALL have parameter CNTBITS, default 16, meaning statistics counter width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port i_clk  in  1  clock, rising edge.
REQ-005 SHALL have port i_reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_ID_Rs  in  RNBITS  rs index of the instruction in ID.
REQ-007 SHALL have port i_ID_Rt  in  RNBITS  rt index of the instruction in ID.
REQ-008 SHALL have port i_ID_UsesRt  in  1  meaning the ID instruction reads rt as a source.
REQ-009 SHALL have port i_EX_MemRead  in  1  MemRead control currently held in the ID/EX register.
REQ-010 SHALL have port i_EX_Rt  in  RNBITS  Rt currently held in the ID/EX register.
REQ-011 SHALL have port i_MEM_Taken  in  1  meaning a branch or jump is resolved taken in MEM.
REQ-012 SHALL have port i_MemBusy  in  1  meaning the data memory requests a wait.
REQ-013 SHALL have port o_PC_Write  out  1  PC load enable.
REQ-014 SHALL have port o_IFID_Write  out  1  IF/ID load enable.
REQ-015 SHALL have port o_IFID_Flush  out  1  loads a NOP into IF/ID.
REQ-016 SHALL have port o_IDEX_Bubble  out  1  forces all ID/EX control inputs (EX, M and WB groups) to 0.
REQ-017 SHALL have port o_EXMEM_Flush  out  1  clears the EX/MEM control fields.
REQ-018 SHALL have port o_Freeze  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
REQ-019 SHALL have port o_State  out  2  current FSM state, for debug.

Function
REQ-020 SHALL have FSM states RUN=0, LOAD_STALL=1, FLUSH=2 and MEM_WAIT=3.
REQ-021 SHALL detect load-use when i_EX_MemRead=1, i_EX_Rt!=0 and either i_EX_Rt==i_ID_Rs or (i_ID_UsesRt and i_EX_Rt==i_ID_Rt).
REQ-022 SHALL resolve each cycle with fixed priority: i_MEM_Taken, then i_MemBusy, then load-use.
REQ-023 SHALL generate control outputs combinationally from inputs and state in the same cycle; the state updates on the rising edge of i_clk.
REQ-024 SHALL, on taken, assert o_IFID_Flush=1, o_IDEX_Bubble=1, o_EXMEM_Flush=1, o_PC_Write=1 and o_IFID_Write=1, then enter FLUSH.
REQ-025 SHALL, in FLUSH, assert o_IDEX_Bubble=1 for exactly one cycle (wrong-path instruction still in ID) and then return to RUN unless a new taken, busy or load-use condition applies.
REQ-026 SHALL, on busy, assert o_Freeze=1 and o_PC_Write=0 and o_IFID_Write=0 while i_MemBusy=1, remain in MEM_WAIT, and return to RUN the cycle after i_MemBusy falls.
REQ-027 SHALL, on load-use, assert o_PC_Write=0, o_IFID_Write=0 and o_IDEX_Bubble=1 for exactly 1 cycle and enter LOAD_STALL.
REQ-028 SHALL suppress load-use detection while in LOAD_STALL, so that no back-to-back stall occurs for the same load.
REQ-029 SHALL drive o_PC_Write=1 and o_IFID_Write=1 with all flush, bubble and freeze outputs at 0 when no condition is active.
REQ-030 SHALL let taken preempt MEM_WAIT or LOAD_STALL immediately.
REQ-031 SHALL, when busy and load-use coincide, handle busy first and re-evaluate load-use after the wait.

Reset
REQ-032 SHALL, while i_reset=1, force state RUN and outputs o_PC_Write=0, o_IFID_Write=0, o_IFID_Flush=1, o_IDEX_Bubble=1, o_EXMEM_Flush=1, o_Freeze=0 and o_State=0.
REQ-033 SHALL treat reset asserted mid-stall or mid-wait as abandoning the operation; the first cycle after release is RUN with normal evaluation.

Configuration
REQ-034 SHALL, with HAZARD_STATS_EN defined, add outputs o_StallCount, o_FlushCount and o_WaitCount (CNTBITS each), counting load-use, taken and busy cycles respectively; they saturate at all-ones and reset to 0.
REQ-035 SHALL, without HAZARD_STATS_EN, have neither those ports nor the counters.

Structure
REQ-036 SHALL place the FSM state encodings and the RNBITS default in shared package hazard_pkg.
REQ-037 SHALL implement the load-use comparator as sub-module hazard_loaduse_detect (combinational); the FSM and outputs reside in hazard_unit.

Verification
REQ-038 SHALL verify a load-use stall: EX MemRead=1, EX_Rt=8, ID_Rs=8 -> one cycle with PC_Write=0 and IDEX_Bubble=1, then a cycle with PC_Write=1.
REQ-039 SHALL verify register zero: EX MemRead=1, EX_Rt=0, ID_Rs=0 -> no stall.
REQ-040 SHALL verify rt masking: EX_Rt=9, ID_Rt=9, ID_UsesRt=0 -> no stall; ID_UsesRt=1 -> stall.
REQ-041 SHALL verify taken during a load-use stall: MEM_Taken=1 with load-use=1 -> all three flushes, PC_Write=1, then FLUSH with IDEX_Bubble=1 for one cycle.
REQ-042 SHALL verify a wait: MemBusy=1 for 3 cycles -> Freeze=1 for 3 cycles, state 3, RUN on the 4th; with HAZARD_STATS_EN, WaitCount=3.
REQ-043 SHALL verify reset in MEM_WAIT: reset pulse -> reset output values, state 0, then normal operation after release.
